// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Takes a length-prefixed, XOR-checksummed byte stream and assembles
// little-endian 32-bit words. It writes them to instruction memory from
// word 0 and holds the pipeline in reset until the checksum is confirmed.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Word index must reach MAX_WORDS itself, one bit wider than a word address.
    localparam int unsigned IDX_W = ADDR_WIDTH - 1;
    localparam int unsigned LEN_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    logic [7:0]         len_lo;
    logic [LEN_W-1:0]   word_count;
    logic [IDX_W-1:0]   word_index;
    logic [1:0]         byte_cnt;
    logic [23:0]        assembly;
    logic [7:0]         run_xor;

    logic               xfer;
    logic [LEN_W-1:0]   len_full;
    logic [31:0]        next_word;
    logic [LEN_W-1:0]   next_index;

    // Handshake and datapath helpers.
    assign xfer       = in_valid && in_ready;
    assign len_full   = {in_data, len_lo};
    assign next_word  = {in_data, assembly};
    assign next_index = LEN_W'(word_index) + LEN_W'(1);

    // Load sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            len_lo     <= 8'd0;
            word_count <= '0;
            word_index <= '0;
            byte_cnt   <= 2'd0;
            assembly   <= 24'd0;
            run_xor    <= 8'd0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse.
            imem_we <= 1'b0;

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state      <= S_LEN_LO;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        core_reset <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        run_xor    <= 8'd0;
                        byte_cnt   <= 2'd0;
                        word_index <= '0;
                    end
                end

                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo  <= in_data;
                        run_xor <= run_xor ^ in_data;
                        state   <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (xfer) begin
                        word_count <= len_full;
                        run_xor    <= run_xor ^ in_data;
                        if (len_full > LEN_W'(MAX_WORDS)) begin
                            // Oversized image: reject before touching memory.
                            state    <= S_ERROR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else if (len_full == '0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        // First byte of a word ends up in bits [7:0].
                        assembly <= next_word[31:8];
                        run_xor  <= run_xor ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state      <= S_WRITE;
                            in_ready   <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_addr  <= {word_index[ADDR_WIDTH-3:0], 2'b00};
                            imem_wdata <= next_word;
                        end
                    end
                end

                S_WRITE: begin
                    word_index <= word_index + IDX_W'(1);
                    in_ready   <= 1'b1;
                    if (next_index == word_count) begin
                        state <= S_CHECK;
                    end else begin
                        state <= S_DATA;
                    end
                end

                S_CHECK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == run_xor) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
